// File: rtl/core_id_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_id_issue_ctrl_pkg
// Shared constants and types for the ID->EX issue controller:
//   RF_NUM        number of architectural integer registers (scoreboard depth)
//   RFIDX_W       register index width
//   MAX_INFLIGHT  maximum issued-but-not-written-back register writes (1..15)
//   CNT_W         in-flight counter width, 2**CNT_W > MAX_INFLIGHT
//   issue_state_e issue FSM encoding (RUN / DRAIN)
//   idx_onehot    register index -> one-hot busy mask
// -----------------------------------------------------------------------------
package core_id_issue_ctrl_pkg;

    localparam int unsigned RF_NUM       = 32;
    localparam int unsigned RFIDX_W      = 5;
    localparam int unsigned MAX_INFLIGHT = 4;
    localparam int unsigned CNT_W        = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } issue_state_e;

    // One-hot mask selecting a single scoreboard bit.
    function automatic logic [RF_NUM-1:0] idx_onehot(input logic [RFIDX_W-1:0] idx);
        logic [RF_NUM-1:0] oh;
        oh      = {RF_NUM{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/core_id_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// core_id_issue_ctrl_if
// Handshake bundle between decode (ID), execute (EX), write-back (WB) and the
// issue controller.
//   master : environment side (drives the ID instruction, ex_ready, WB retire)
//   slave  : issue controller side (drives id_ready and ex_valid)
// -----------------------------------------------------------------------------
interface core_id_issue_ctrl_if;
    import core_id_issue_ctrl_pkg::*;

    logic               id_valid;
    logic               id_ready;
    logic               id_rs1_ren;
    logic               id_rs2_ren;
    logic               id_rd_wen;
    logic [RFIDX_W-1:0] id_rs1_idx;
    logic [RFIDX_W-1:0] id_rs2_idx;
    logic [RFIDX_W-1:0] id_rd_idx;
    logic               id_serial;
    logic               ex_valid;
    logic               ex_ready;
    logic               wb_valid;
    logic [RFIDX_W-1:0] wb_rd_idx;

    modport master (
        output id_valid, id_rs1_ren, id_rs2_ren, id_rd_wen,
               id_rs1_idx, id_rs2_idx, id_rd_idx, id_serial,
               ex_ready, wb_valid, wb_rd_idx,
        input  id_ready, ex_valid
    );

    modport slave (
        input  id_valid, id_rs1_ren, id_rs2_ren, id_rd_wen,
               id_rs1_idx, id_rs2_idx, id_rd_idx, id_serial,
               ex_ready, wb_valid, wb_rd_idx,
        output id_ready, ex_valid
    );

endinterface

// File: rtl/core_id_scoreboard.sv
// -----------------------------------------------------------------------------
// core_id_scoreboard
// Per-register busy bits for in-flight destination writes, hazard lookups,
// in-flight write counter and sticky protocol-error flag.
//   clk, rst            clock, synchronous active-high reset
//   rs1/rs2 ren+idx     source lookups -> raw
//   rd_wen, rd_idx      destination lookup -> waw, full
//   issue               instruction handed to EX this cycle (sets busy[rd])
//   wb_valid, wb_rd_idx retiring register write (clears busy[wb])
//   raw, waw, full      hazards on the registered scoreboard (no wb bypass)
//   cnt_zero            no writes in flight
//   busy_vec, inflight_cnt, sb_err  registered state
// -----------------------------------------------------------------------------
module core_id_scoreboard
    import core_id_issue_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rs1_ren,
    input  logic [RFIDX_W-1:0] rs1_idx,
    input  logic               rs2_ren,
    input  logic [RFIDX_W-1:0] rs2_idx,
    input  logic               rd_wen,
    input  logic [RFIDX_W-1:0] rd_idx,
    input  logic               issue,
    input  logic               wb_valid,
    input  logic [RFIDX_W-1:0] wb_rd_idx,
    output logic               raw,
    output logic               waw,
    output logic               full,
    output logic               cnt_zero,
    output logic [RF_NUM-1:0]  busy_vec,
    output logic [CNT_W-1:0]   inflight_cnt,
    output logic               sb_err
);

    logic [RF_NUM-1:0] busy_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              err_r;

    logic              rd_nz_s;
    logic              wb_nz_s;
    logic              set_s;
    logic              clr_s;
    logic              err_s;
    logic [RF_NUM-1:0] busy_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;

    // busy_r[0] is held at zero, so index 0 can never produce a hazard.
    assign raw      = (rs1_ren & busy_r[rs1_idx]) | (rs2_ren & busy_r[rs2_idx]);
    assign waw      = rd_wen & busy_r[rd_idx];
    assign rd_nz_s  = (rd_idx != {RFIDX_W{1'b0}});
    assign wb_nz_s  = (wb_rd_idx != {RFIDX_W{1'b0}});
    assign cnt_zero = (cnt_r == {CNT_W{1'b0}});
    assign full     = rd_wen & rd_nz_s & (cnt_r == CNT_W'(MAX_INFLIGHT));

    assign set_s    = issue & rd_wen & rd_nz_s;
    assign clr_s    = wb_valid & wb_nz_s & busy_r[wb_rd_idx];
    // A retire that matches nothing in flight is a protocol error.
    assign err_s    = wb_valid & ~clr_s & (wb_nz_s | cnt_zero);

    // Next scoreboard and counter: clear on retire, set on issue.
    always_comb begin
        busy_nxt_s = busy_r;
        cnt_nxt_s  = cnt_r;
        if (clr_s) begin
            busy_nxt_s = busy_nxt_s & ~idx_onehot(wb_rd_idx);
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (set_s) begin
            busy_nxt_s = busy_nxt_s | idx_onehot(rd_idx);
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
        // full blocks a set at MAX_INFLIGHT and clr needs a busy bit, so no wrap.
        case ({set_s, clr_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Scoreboard state registers with sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {RF_NUM{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            err_r  <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
            err_r  <= err_r | err_s;
        end
    end

    assign busy_vec     = busy_r;
    assign inflight_cnt = cnt_r;
    assign sb_err       = err_r;

endmodule

// File: rtl/core_id_issue_ctrl.sv
// -----------------------------------------------------------------------------
// core_id_issue_ctrl
// Decides each cycle whether the decoded ID instruction may be handed to EX.
// Stalls on RAW/WAW hazards against the busy scoreboard, on the in-flight
// limit, drains the pipeline ahead of serialising instructions, and drops the
// ID instruction on flush.
//   clk, rst      clock, synchronous active-high reset
//   flush         redirect; suppresses issue this cycle, leaves scoreboard
//   io (slave)    ID/EX/WB handshake bundle; ex_valid = id_ready = issue
//   busy_vec      scoreboard (debug/perf)
//   inflight_cnt  in-flight register write count
//   sb_err        sticky protocol-error flag
// -----------------------------------------------------------------------------
module core_id_issue_ctrl
    import core_id_issue_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    core_id_issue_ctrl_if.slave  io,
    output logic [RF_NUM-1:0]    busy_vec,
    output logic [CNT_W-1:0]     inflight_cnt,
    output logic                 sb_err
);

    issue_state_e state_r;

    logic raw_s;
    logic waw_s;
    logic full_s;
    logic cnt_zero_s;
    logic issue_s;
    logic drain_req_s;

    core_id_scoreboard u_sb (
        .clk          (clk),
        .rst          (rst),
        .rs1_ren      (io.id_rs1_ren),
        .rs1_idx      (io.id_rs1_idx),
        .rs2_ren      (io.id_rs2_ren),
        .rs2_idx      (io.id_rs2_idx),
        .rd_wen       (io.id_rd_wen),
        .rd_idx       (io.id_rd_idx),
        .issue        (issue_s),
        .wb_valid     (io.wb_valid),
        .wb_rd_idx    (io.wb_rd_idx),
        .raw          (raw_s),
        .waw          (waw_s),
        .full         (full_s),
        .cnt_zero     (cnt_zero_s),
        .busy_vec     (busy_vec),
        .inflight_cnt (inflight_cnt),
        .sb_err       (sb_err)
    );

    // Issue decision; a serial instruction is ordinary once nothing is in flight.
    always_comb begin
        issue_s     = 1'b0;
        drain_req_s = 1'b0;
        if (rst) begin
            issue_s     = 1'b0;
            drain_req_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    issue_s     = io.id_valid & io.ex_ready & ~flush & ~raw_s &
                                  ~waw_s & ~full_s & (~io.id_serial | cnt_zero_s);
                    drain_req_s = io.id_valid & io.id_serial & ~flush & ~cnt_zero_s;
                end
                ST_DRAIN: begin
                    issue_s     = 1'b0;
                    drain_req_s = 1'b0;
                end
                default: begin
                    issue_s     = 1'b0;
                    drain_req_s = 1'b0;
                end
            endcase
        end
    end

    // Issue FSM; DRAIN leaves one cycle after the count is seen at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (drain_req_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (flush || cnt_zero_s) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: state_r <= ST_RUN;
            endcase
        end
    end

    assign io.ex_valid = issue_s;
    assign io.id_ready = issue_s;

endmodule
